// File: rtl/shot_launcher_pkg.sv
// ============================================================================
// Module   : shot_launcher_pkg
// Brief    : Shared shot-interface widths, FSM state codes and magazine default
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shot_launcher_pkg;

    localparam int c_X_W                = 11;
    localparam int c_Y_W                = 10;
    localparam int c_SHOT_LIMIT_DEFAULT = 20;

    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_FIRE    = 2'd1;
    localparam state_t c_ST_HOLDOFF = 2'd2;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module   : button_debounce
// Brief    : Accepts a new button level after DEBOUNCE stable cycles; 1-cycle rise pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter int DEBOUNCE = 650_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int c_CNT_W = $clog2(DEBOUNCE + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;

    // r_cnt counts consecutive cycles in which raw disagrees with the accepted level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_W'(DEBOUNCE - 1)) begin
                r_cnt   <= '0;
                r_level <= raw;
                r_rise  <= raw;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/shot_launcher.sv
// ============================================================================
// Module   : shot_launcher
// Brief    : Debounced fire/reload front end driving the trigger/x/y shot interface
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shot_launcher
    import shot_launcher_pkg::*;
#(
    parameter int SHOT_LIMIT  = c_SHOT_LIMIT_DEFAULT,
    parameter int DEBOUNCE    = 650_000,
    parameter int TRIGGER_LEN = 4,
    parameter int COOLDOWN    = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            fire_btn,
    input  logic                            reload_btn,
    input  logic [c_X_W-1:0]                aim_x,
    input  logic [c_Y_W-1:0]                aim_y,
    input  logic                            aim_valid,
    input  logic                            busy,
    output logic                            trigger,
    output logic [c_X_W-1:0]                x,
    output logic [c_Y_W-1:0]                y,
    output logic                            clear,
    output logic [$clog2(SHOT_LIMIT+1)-1:0] shots_left,
    output logic                            empty
);

    localparam int c_SHOTS_W = $clog2(SHOT_LIMIT + 1);
    localparam int c_TMR_MAX = (TRIGGER_LEN > COOLDOWN) ? TRIGGER_LEN : COOLDOWN;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    logic w_fire_rise;
    logic w_reload_rise;
    logic w_fire_level;
    logic w_reload_level;
    logic w_unused_levels;

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_fire_db (
        .clk   (clk),
        .reset (reset),
        .raw   (fire_btn),
        .level (w_fire_level),
        .rise  (w_fire_rise)
    );

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_reload_db (
        .clk   (clk),
        .reset (reset),
        .raw   (reload_btn),
        .level (w_reload_level),
        .rise  (w_reload_rise)
    );

    assign w_unused_levels = w_fire_level ^ w_reload_level;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_TMR_W-1:0]   r_tmr;
    logic [c_TMR_W-1:0]   w_tmr_nxt;
    logic [c_SHOTS_W-1:0] r_shots;
    logic [c_SHOTS_W-1:0] w_shots_nxt;
    logic [c_X_W-1:0]     r_x;
    logic [c_X_W-1:0]     w_x_nxt;
    logic [c_Y_W-1:0]     r_y;
    logic [c_Y_W-1:0]     w_y_nxt;
    logic                 r_clear;
    logic                 w_clear_nxt;
    logic                 r_trigger;
    logic                 r_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_shots_nxt = r_shots;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_clear_nxt = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_reload_rise) begin
                    w_clear_nxt = 1'b1;
                    w_shots_nxt = c_SHOTS_W'(SHOT_LIMIT);
                end else if (w_fire_rise && aim_valid && !busy && (r_shots != '0)) begin
                    w_x_nxt     = aim_x;
                    w_y_nxt     = aim_y;
                    w_shots_nxt = r_shots - c_SHOTS_W'(1);
                    w_tmr_nxt   = c_TMR_W'(TRIGGER_LEN - 1);
                    w_state_nxt = c_ST_FIRE;
                end
            end
            c_ST_FIRE: begin
                if (r_tmr == '0) begin
                    w_tmr_nxt   = c_TMR_W'(COOLDOWN - 1);
                    w_state_nxt = c_ST_HOLDOFF;
                end else begin
                    w_tmr_nxt = r_tmr - c_TMR_W'(1);
                end
            end
            c_ST_HOLDOFF: begin
                if (w_reload_rise) begin
                    w_clear_nxt = 1'b1;
                    w_shots_nxt = c_SHOTS_W'(SHOT_LIMIT);
                end
                // Cooldown done: wait here for the hit-marker to finish counting
                if (r_tmr == '0) begin
                    if (!busy) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - c_TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_tmr     <= '0;
            r_shots   <= c_SHOTS_W'(SHOT_LIMIT);
            r_x       <= '0;
            r_y       <= '0;
            r_clear   <= 1'b0;
            r_trigger <= 1'b0;
            r_empty   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmr     <= w_tmr_nxt;
            r_shots   <= w_shots_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_clear   <= w_clear_nxt;
            r_trigger <= (w_state_nxt == c_ST_FIRE);
            r_empty   <= (w_shots_nxt == '0);
        end
    end

    assign trigger    = r_trigger;
    assign x          = r_x;
    assign y          = r_y;
    assign clear      = r_clear;
    assign shots_left = r_shots;
    assign empty      = r_empty;

endmodule

`default_nettype wire

// File: tb/tb_shot_launcher.sv
// ============================================================================
// Module   : tb_shot_launcher
// Brief    : Self-checking bench for shot_launcher against a timeline-based model
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shot_launcher;

    localparam int DEB = 4;
    localparam int TL  = 2;
    localparam int CD  = 3;
    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        fire_btn;
    logic        reload_btn;
    logic [10:0] aim_x;
    logic [9:0]  aim_y;
    logic        aim_valid;
    logic        busy;
    logic        trigger;
    logic [10:0] x;
    logic [9:0]  y;
    logic        clear;
    logic [1:0]  shots_left;
    logic        empty;

    always #5 clk = ~clk;

    shot_launcher #(
        .SHOT_LIMIT  (LIM),
        .DEBOUNCE    (DEB),
        .TRIGGER_LEN (TL),
        .COOLDOWN    (CD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fire_btn   (fire_btn),
        .reload_btn (reload_btn),
        .aim_x      (aim_x),
        .aim_y      (aim_y),
        .aim_valid  (aim_valid),
        .busy       (busy),
        .trigger    (trigger),
        .x          (x),
        .y          (y),
        .clear      (clear),
        .shots_left (shots_left),
        .empty      (empty)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a shot is a time window [t_acc+1, t_acc+TL] of trigger,
    // followed by at least CD low cycles and then any remaining busy cycles.
    bit     m_trigger, m_clear, m_empty;
    int     m_x, m_y, m_shots;
    bit     f_lvl, r_lvl, m_frise, m_rrise;
    int     f_run, r_run;
    bit     in_shot;
    longint cyc = 0;
    longint t_acc = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_trigger = 0; m_clear = 0; m_empty = 0;
            m_x = 0; m_y = 0; m_shots = LIM;
            f_lvl = 0; r_lvl = 0; f_run = 0; r_run = 0;
            m_frise = 0; m_rrise = 0; in_shot = 0;
        end else begin
            m_clear = 0;
            if (in_shot && cyc > t_acc + TL) begin
                if (m_rrise) begin m_clear = 1; m_shots = LIM; end
                if (cyc >= t_acc + TL + CD && !busy) in_shot = 0;
            end else if (!in_shot) begin
                if (m_rrise) begin
                    m_clear = 1; m_shots = LIM;
                end else if (m_frise && aim_valid && !busy && m_shots > 0) begin
                    in_shot = 1; t_acc = cyc;
                    m_x = int'(aim_x); m_y = int'(aim_y);
                    m_shots = m_shots - 1;
                end
            end
            m_empty = (m_shots == 0);
            m_frise = 0;
            if (fire_btn != f_lvl) begin
                f_run++;
                if (f_run == DEB) begin f_lvl = fire_btn; f_run = 0; m_frise = fire_btn; end
            end else f_run = 0;
            m_rrise = 0;
            if (reload_btn != r_lvl) begin
                r_run++;
                if (r_run == DEB) begin r_lvl = reload_btn; r_run = 0; m_rrise = reload_btn; end
            end else r_run = 0;
            cyc++;
            m_trigger = in_shot && (cyc <= t_acc + TL);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("trigger",    int'(trigger),    int'(m_trigger));
            chk("x",          int'(x),          m_x);
            chk("y",          int'(y),          m_y);
            chk("clear",      int'(clear),      int'(m_clear));
            chk("shots_left", int'(shots_left), m_shots);
            chk("empty",      int'(empty),      int'(m_empty));
        end
    end

    int trig_rises   = 0;
    int clear_cycles = 0;
    bit prev_trig    = 0;

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (trigger && !prev_trig) trig_rises++;
            if (clear) clear_cycles++;
            prev_trig = trigger;
        end
    endtask

    task automatic press(input bit f, input bit r);
        fire_btn = f; reload_btn = r;
        run(8);
        fire_btn = 0; reload_btn = 0;
        run(8);
    endtask

    task automatic clr_counts();
        trig_rises = 0; clear_cycles = 0;
    endtask

    initial begin
        reset = 0; fire_btn = 0; reload_btn = 0;
        aim_x = 11'd100; aim_y = 10'd50; aim_valid = 1; busy = 0;
        #1 reset = 1;
        @(negedge clk);
        chk("rst_trigger", int'(trigger), 0);
        chk("rst_shots",   int'(shots_left), 3);
        chk("rst_empty",   int'(empty), 0);
        chk("rst_x",       int'(x), 0);
        run(2);
        reset = 0;
        run(2);

        // Single shot: raw high in cycle 0, trigger in cycles 5 and 6
        fire_btn = 1;
        for (int k = 1; k <= 8; k++) begin
            run(1);
            chk("single_trig", int'(trigger), (k == 5 || k == 6) ? 1 : 0);
            if (k == 4) chk("single_shots_pre", int'(shots_left), 3);
            if (k == 5) begin
                chk("single_x", int'(x), 100);
                chk("single_y", int'(y), 50);
                chk("single_shots", int'(shots_left), 2);
            end
        end
        fire_btn = 0;
        run(12);

        // Bounce: toggle every 2 cycles
        clr_counts();
        for (int i = 0; i < 10; i++) begin
            fire_btn = ~fire_btn;
            run(2);
        end
        fire_btn = 0;
        run(8);
        chk("bounce_rises", trig_rises, 0);
        chk("bounce_shots", int'(shots_left), 2);

        // Busy, then invalid aim, then a good press
        clr_counts();
        busy = 1; press(1, 0); busy = 0;
        chk("busy_rises", trig_rises, 0);
        chk("busy_shots", int'(shots_left), 2);
        aim_valid = 0; press(1, 0); aim_valid = 1;
        chk("inval_rises", trig_rises, 0);
        chk("inval_shots", int'(shots_left), 2);
        aim_x = 11'd1500; aim_y = 10'd900;
        press(1, 0);
        chk("after_busy_rises", trig_rises, 1);
        chk("after_busy_shots", int'(shots_left), 1);
        chk("after_busy_x", int'(x), 1500);

        // Refill, then exhaust the magazine
        clr_counts();
        press(0, 1);
        chk("refill_clear", clear_cycles, 1);
        chk("refill_shots", int'(shots_left), 3);
        clr_counts();
        repeat (4) press(1, 0);
        chk("exhaust_rises", trig_rises, 3);
        chk("exhaust_empty", int'(empty), 1);
        chk("exhaust_shots", int'(shots_left), 0);
        press(0, 1);
        chk("reload_clear", clear_cycles, 1);
        chk("reload_shots", int'(shots_left), 3);
        chk("reload_empty", int'(empty), 0);
        chk("reload_x_kept", int'(x), 1500);

        // Simultaneous fire and reload edges
        press(1, 0);
        clr_counts();
        press(1, 1);
        chk("simul_rises", trig_rises, 0);
        chk("simul_clear", clear_cycles, 1);
        chk("simul_shots", int'(shots_left), 3);

        // Reset during FIRE
        fire_btn = 1;
        run(5);
        chk("pre_rst_trig", int'(trigger), 1);
        #2 reset = 1;
        #1;
        chk("mid_rst_trig", int'(trigger), 0);
        chk("mid_rst_shots", int'(shots_left), 3);
        fire_btn = 0;
        run(2);
        reset = 0;
        prev_trig = 0;
        run(2);
        clr_counts();
        press(1, 0);
        chk("post_rst_rises", trig_rises, 1);
        chk("post_rst_shots", int'(shots_left), 2);

        // Randomised traffic checked cycle by cycle against the model
        repeat (400) begin
            fire_btn   = 1'($urandom_range(0, 1));
            reload_btn = ($urandom_range(0, 9) == 0);
            busy       = ($urandom_range(0, 3) == 0);
            aim_valid  = ($urandom_range(0, 7) != 0);
            aim_x      = 11'($urandom_range(0, 2047));
            aim_y      = 10'($urandom_range(0, 1023));
            run($urandom_range(1, 12));
        end
        fire_btn = 0; reload_btn = 0; busy = 0;
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shot_launcher.md
# shot_launcher

Firing-side front end for the target display. It debounces the player's fire and reload buttons and captures the current aim coordinates when a shot is fired. It then drives the `trigger`/`x`/`y` shot interface consumed by the hit-marker block. It also:
- enforces the magazine size and the re-fire spacing that block depends on (clean trigger rising edges, no shot while it is counting);
- issues the `clear` pulse that wipes the display on reload.

## Interface
Parameters:
- `SHOT_LIMIT`, 20: magazine size. Must equal the hit-marker block's `SHOT_LIMIT`.
- `DEBOUNCE`, 650_000: cycles a raw button level must be stable before it is accepted (10 ms at 65 MHz).
- `TRIGGER_LEN`, 4: cycles `trigger` is held high per shot (≥1).
- `COOLDOWN`, 32: minimum cycles after `trigger` falls before the next shot can start (≥1).

Ports:
- `clk`  in  1  pixel clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `fire_btn`  in  1  raw, already metastability-synchronised fire button.
- `reload_btn`  in  1  raw, already synchronised reload button.
- `aim_x`  in  11  current aim column.
- `aim_y`  in  10  current aim row.
- `aim_valid`  in  1  aim coordinates are meaningful this cycle.
- `busy`  in  1  hit-marker block is counting (its `see_counting`).
- `trigger`  out  1  shot strobe, high for TRIGGER_LEN cycles.
- `x`  out  11  latched shot column, stable whenever `trigger` is high.
- `y`  out  10  latched shot row, stable whenever `trigger` is high.
- `clear`  out  1  one-cycle display/score wipe on reload.
- `shots_left`  out  $clog2(SHOT_LIMIT+1)  rounds remaining.
- `empty`  out  1  `shots_left == 0`.

## Operation
- Each button goes through its own debouncer. A debounced level changes only after the raw input has differed from it for DEBOUNCE consecutive cycles. Only debounced rising edges (`fire_rise`, `reload_rise`, 1-cycle pulses) are used.
- FSM states and transitions:
  - **IDLE**:
    - `reload_rise` → pulse `clear`, set `shots_left` to SHOT_LIMIT, stay in IDLE. Reload takes priority over a same-cycle `fire_rise`; that fire is dropped.
    - Otherwise, `fire_rise && aim_valid && !busy && shots_left != 0` → latch `aim_x`/`aim_y` into `x`/`y`, decrement `shots_left`, go to FIRE.
    - `fire_rise` failing any of those conditions is discarded, not queued.
  - **FIRE**: `trigger` = 1 for exactly TRIGGER_LEN cycles, then go to HOLDOFF. `reload_rise` is ignored here.
  - **HOLDOFF**: `trigger` = 0. Stay until COOLDOWN cycles have elapsed **and** `busy` is 0, then go to IDLE. `reload_rise` in this state is handled exactly as in IDLE (clear, refill) and the state is unchanged.
  - **EMPTY** is not a separate state. It is IDLE with `shots_left == 0`, reported on `empty`.
- `x`/`y` change only on shot acceptance. They hold their value otherwise, including through reload.
- `shots_left` saturates at 0 and never wraps. Reload when already full still pulses `clear`.

## Timing
- Reset values: `trigger` 0, `x` 0, `y` 0, `clear` 0, `shots_left` SHOT_LIMIT, `empty` 0, FSM IDLE, debounced levels 0, all counters 0.
- Reset asserted mid-FIRE drops `trigger` immediately (asynchronously).
- All outputs are registered.
- Fire latency: raw fire goes high at cycle 0 → `fire_rise` at cycle DEBOUNCE → `trigger` high from DEBOUNCE+1 through DEBOUNCE+TRIGGER_LEN.
- `x`/`y`/`shots_left` update in the same cycle `trigger` first rises.
- Minimum shot period is TRIGGER_LEN + COOLDOWN + 1 cycles (the +1 is the IDLE acceptance cycle). `trigger` is low for at least COOLDOWN cycles between shots, so every shot presents a fresh rising edge downstream.
- `clear` is high in the cycle after `reload_rise`, for exactly 1 cycle.
- A button held indefinitely produces one edge only; a release must be debounced before the next press counts.

## Structure
- Shared include: FSM state constants (IDLE/FIRE/HOLDOFF), the shot-coordinate widths (11/10), and the default SHOT_LIMIT, so the hit-marker block and this block agree.
- One sub-module: `button_debounce` (params DEBOUNCE; ports `clk`, `reset`, `raw`, `level`, `rise`). Instantiate it twice.
- The FSM, the TRIGGER_LEN/COOLDOWN counter (one shared down-counter) and the magazine counter live in the top module.

## Test plan
Bench parameters: DEBOUNCE=4, TRIGGER_LEN=2, COOLDOWN=3, SHOT_LIMIT=3.
- **Single shot.** Aim (100,50) valid; fire high from cycle 0 → `trigger` high cycles 5–6, x=100, y=50, `shots_left` 3→2 at cycle 5.
- **Bounce rejection.** Fire toggles every 2 cycles for 20 cycles → `trigger` never rises.
- **Busy and invalid aim.** Press while `busy`=1, and separately while `aim_valid`=0 → press dropped, `shots_left` unchanged. Press again after `busy` falls → shot accepted.
- **Magazine exhaustion.** 4 separated presses → exactly 3 trigger pulses, `empty`=1, 4th press ignored. Reload → one-cycle `clear`, `shots_left`=3, `empty`=0.
- **Simultaneous edges.** `fire_rise` and `reload_rise` in the same IDLE cycle → `clear` pulses, no trigger, `shots_left`=SHOT_LIMIT.
- **Reset mid-shot.** Assert `reset` during FIRE → `trigger` 0 immediately, `shots_left`=3. After release, the next press fires normally.
